// File: rtl/fetch_path.sv
// ============================================================================
// fetch_path
// ----------------------------------------------------------------------------
// Fetch stage of a 5-stage pipeline. Owns the program counter, drives the
// instruction-memory request/ack handshake and fills the IF/ID register that
// feeds the decode stage. The decode stage resolves branches and hands back
// pc_src_D / pc_br_D; wrong-path fetches are discarded here.
//
// Ports
//   clk          in   1   sole clock, all state updates on posedge
//   reset        in   1   synchronous, active-high
//   imem_req     out  1   instruction fetch request
//   imem_addr    out  32  fetch address (word aligned)
//   imem_ack     in   1   fetch complete this cycle, imem_rdata valid
//   imem_rdata   in   32  fetched instruction
//   stall_D      in   1   hazard unit: hold IF/ID
//   flush_D      in   1   hazard unit: bubble IF/ID
//   pc_src_D     in   1   branch taken, resolved in decode
//   pc_br_D      in   32  branch target (low two bits ignored)
//   inst_D       out  32  IF/ID instruction
//   pc_plus4_D   out  32  IF/ID PC+4
//   valid_D      out  1   IF/ID holds a real instruction
//
// Fetch FSM
//   FETCH : request outstanding at pc_q.
//   HOLD  : an instruction arrived while decode was stalled; it is parked in
//           buf_q and no request is issued until decode can take it.
//   DRAIN : a redirect arrived while a request was still outstanding. The
//           memory must see a stable address until it acks, so the old
//           request is kept alive, its data is dropped, and the fetch then
//           restarts at the saved redirect target.
// ============================================================================
module fetch_path #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_D,
   input  logic        flush_D,
   input  logic        pc_src_D,
   input  logic [31:0] pc_br_D,
   output logic [31:0] inst_D,
   output logic [31:0] pc_plus4_D,
   output logic        valid_D
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic [31:0] buf_q, buf_d;
   logic        req_q, req_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect_s;
   logic [31:0] br_tgt_s;
   logic [31:0] pc_plus4_s;
   logic        deliver_s;
   logic [31:0] deliver_inst_s;

   // Branch decision: only a live, unstalled instruction in decode may redirect.
   always_comb begin
      redirect_s = pc_src_D & valid_q & ~stall_D;
      // Mask rather than slice so every target bit is consumed; targets are
      // always word aligned.
      br_tgt_s   = pc_br_D & 32'hFFFF_FFFC;
      // Modulo-2^32 increment; wrap-around is intentional and silent.
      pc_plus4_s = pc_q + 32'd4;
   end

   // Fetch FSM next-state, PC update and delivery selection.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      redir_pc_d     = redir_pc_q;
      buf_d          = buf_q;
      deliver_s      = 1'b0;
      deliver_inst_s = imem_rdata;
      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               if (redirect_s) begin
                  // Wrong-path data: drop it and restart at the target.
                  pc_d = br_tgt_s;
               end else if (!stall_D) begin
                  deliver_s      = 1'b1;
                  deliver_inst_s = imem_rdata;
                  pc_d           = pc_plus4_s;
               end else begin
                  // Decode cannot accept; park the word until it can.
                  buf_d   = imem_rdata;
                  state_d = HOLD;
               end
            end else if (redirect_s) begin
               redir_pc_d = br_tgt_s;
               state_d    = DRAIN;
            end else begin
               state_d = FETCH;
            end
         end
         HOLD: begin
            if (redirect_s) begin
               pc_d    = br_tgt_s;
               state_d = FETCH;
            end else if (!stall_D) begin
               deliver_s      = 1'b1;
               deliver_inst_s = buf_q;
               pc_d           = pc_plus4_s;
               state_d        = FETCH;
            end else begin
               state_d = HOLD;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               // A redirect landing on the ack cycle is the newest target.
               if (redirect_s) begin
                  pc_d = br_tgt_s;
               end else begin
                  pc_d = redir_pc_q;
               end
               state_d = FETCH;
            end else if (redirect_s) begin
               redir_pc_d = br_tgt_s;
               state_d    = DRAIN;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = FETCH;
            pc_d    = pc_q;
         end
      endcase
      // No request while parked in HOLD; the address only changes after an ack.
      req_d = (state_d != HOLD);
   end

   // IF/ID register next value: flush/redirect > stall > delivery > bubble.
   always_comb begin
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush_D || redirect_s) begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (stall_D) begin
         inst_d  = inst_q;
         valid_d = valid_q;
      end else if (deliver_s) begin
         // Delivered PC is always pc_q (HOLD never advances the PC).
         inst_d  = deliver_inst_s;
         pc4_d   = pc_plus4_s;
         valid_d = 1'b1;
      end else begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end
   end

   // State, PC and IF/ID registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         redir_pc_q <= 32'h0000_0000;
         buf_q      <= 32'h0000_0000;
         req_q      <= 1'b1;
         inst_q     <= NOP_INST;
         pc4_q      <= 32'h0000_0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redir_pc_q <= redir_pc_d;
         buf_q      <= buf_d;
         req_q      <= req_d;
         inst_q     <= inst_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign inst_D     = inst_q;
   assign pc_plus4_D = pc4_q;
   assign valid_D    = valid_q;

endmodule
